// File: rtl/apb_if.sv
// APB bus bundle between a requester and the timer peripheral.
// Zero-wait-state subset: no pready or pslverr.
interface apb_if;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata
  );
endinterface

// File: rtl/apb_timer.sv
// APB down-counting timer: prescaler, one-shot/auto-reload,
// sticky expiry flag and a registered level interrupt.
module apb_timer #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  apb_if.slave  apb,
  output logic  irq
);

  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_LOAD = 12'h004;
  localparam logic [11:0] A_CNT  = 12'h008;
  localparam logic [11:0] A_STAT = 12'h00C;

  logic               en_q, en_d;
  logic               auto_q, auto_d;
  logic               ien_q, ien_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               expired_q, expired_d;
  logic               irq_q, irq_d;
  logic [31:0]        prdata_q, prdata_d;

  logic [11:0] addr;
  logic        setup_rd;
  logic        wr;
  logic        sel_ctrl, sel_load, sel_cnt, sel_stat;
  logic        wr_ctrl, wr_load, wr_stat;
  logic        tick;
  logic [31:0] rdata;
  logic [31:0] ctrl_rd;
  logic        unused_addr;

  assign addr     = apb.paddr[11:0];
  assign setup_rd = apb.psel & ~apb.penable & ~apb.pwrite;
  assign wr       = apb.psel & apb.penable & apb.pwrite;

  assign sel_ctrl = (addr == A_CTRL);
  assign sel_load = (addr == A_LOAD);
  assign sel_cnt  = (addr == A_CNT);
  assign sel_stat = (addr == A_STAT);

  assign wr_ctrl = wr & sel_ctrl;
  assign wr_load = wr & sel_load;
  assign wr_stat = wr & sel_stat;

  assign unused_addr = ^apb.paddr[31:12];

  assign tick = en_q && (pcnt_q == presc_q);

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[0] = en_q;
    ctrl_rd[1] = auto_q;
    ctrl_rd[2] = ien_q;
    ctrl_rd[16 +: PRESC_W] = presc_q;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl: rdata = ctrl_rd;
      sel_load: rdata[CNT_W-1:0] = load_q;
      sel_cnt:  rdata[CNT_W-1:0] = count_q;
      sel_stat: rdata[0] = expired_q;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    ien_d     = ien_q;
    presc_d   = presc_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    prdata_d  = prdata_q;

    // Wraps only on equality; a lowered PRESC rolls over naturally.
    if (!en_q)
      pcnt_d = '0;
    else if (tick)
      pcnt_d = '0;
    else
      pcnt_d = pcnt_q + 1'b1;

    if (wr_stat && apb.pwdata[0])
      expired_d = 1'b0;

    if (tick && !wr_load) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        expired_d = 1'b1;
        if (auto_q)
          count_d = load_q;
        else
          en_d = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_d    = apb.pwdata[0];
      auto_d  = apb.pwdata[1];
      ien_d   = apb.pwdata[2];
      presc_d = apb.pwdata[16 +: PRESC_W];
    end

    if (wr_load) begin
      load_d  = apb.pwdata[CNT_W-1:0];
      count_d = apb.pwdata[CNT_W-1:0];
      pcnt_d  = '0;
    end

    if (setup_rd)
      prdata_d = rdata;

    irq_d = expired_d & ien_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ien_q     <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
      prdata_q  <= '0;
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      ien_q     <= ien_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.prdata = prdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Scenario bench for apb_timer: reads are scored against a queue
// of expected values pushed before each access is driven.
module tb_apb_timer;

  localparam logic [31:0] A_CTRL = 32'h000;
  localparam logic [31:0] A_LOAD = 32'h004;
  localparam logic [31:0] A_CNT  = 32'h008;
  localparam logic [31:0] A_STAT = 32'h00C;
  localparam logic [31:0] A_NONE = 32'h010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   n_run = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];

  apb_if bus ();

  apb_timer #(.CNT_W(32), .PRESC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .apb   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    bus.psel = 1'b1; bus.penable = 1'b0;
    bus.paddr = a; bus.pwrite = 1'b1; bus.pwdata = d;
    @(negedge clk); bus.penable = 1'b1;
    @(negedge clk); bus.psel = 1'b0; bus.penable = 1'b0;
    bus.pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    bus.psel = 1'b1; bus.penable = 1'b0;
    bus.paddr = a; bus.pwrite = 1'b0;
    @(negedge clk); bus.penable = 1'b1; d = bus.prdata;
    @(negedge clk); bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic do_reset();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, e;
    logic [31:0] addrs[5];
    addrs = '{A_CTRL, A_LOAD, A_CNT, A_STAT, A_NONE};
    do_reset();
    n_run++;
    if (irq !== 1'b0 || bus.prdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: irq=%b prdata=%h want 0/0", irq, bus.prdata);
    end
    foreach (addrs[i]) begin
      exp_q.push_back(32'h0);
      apb_rd(addrs[i], rd);
      e = exp_q.pop_front();
      n_run++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL reset_rd[%h]: got %h want %h", addrs[i], rd, e);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd, e;
    logic [31:0] ra[5];
    logic [31:0] rv[5];
    do_reset();
    apb_wr(A_LOAD, 32'd3);
    apb_wr(A_CTRL, 32'h5);
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL os_irq0: got %b want 0", irq);
    end
    // reads start at the edges after the commit: count 3, then 1
    exp_q.push_back(32'd3);
    apb_rd(A_CNT, rd);
    e = exp_q.pop_front(); n_run++;
    if (rd !== e) begin
      n_fail++; $display("FAIL os_cnt_a: got %h want %h", rd, e);
    end
    exp_q.push_back(32'd1);
    apb_rd(A_CNT, rd);
    e = exp_q.pop_front(); n_run++;
    if (rd !== e) begin
      n_fail++; $display("FAIL os_cnt_b: got %h want %h", rd, e);
    end
    n_run++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL os_irq4: got %b want 1", irq);
    end
    ra = '{A_CNT, A_STAT, A_CTRL, A_LOAD, A_CNT};
    rv = '{32'd0, 32'd1, 32'h4, 32'd3, 32'd0};
    foreach (ra[i]) begin
      exp_q.push_back(rv[i]);
      apb_rd(ra[i], rd);
      e = exp_q.pop_front(); n_run++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL os_rd[%0d]: got %h want %h", i, rd, e);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic w;
    do_reset();
    apb_wr(A_LOAD, 32'd1);
    apb_wr(A_CTRL, 32'h0002_0007);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      w = (k == 6);
      n_run++;
      if (irq !== w) begin
        n_fail++; $display("FAIL ar_irq_c%0d: got %b want %b", k, irq, w);
      end
    end
    apb_wr(A_STAT, 32'h1);
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL ar_w1c: got %b want 0", irq);
    end
    for (int k = 9; k <= 12; k++) begin
      @(negedge clk);
      w = (k == 12);
      n_run++;
      if (irq !== w) begin
        n_fail++; $display("FAIL ar_irq_c%0d: got %b want %b", k, irq, w);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd, e;
    do_reset();
    apb_wr(A_LOAD, 32'd1);
    apb_wr(A_CTRL, 32'h0002_0007);
    repeat (4) @(negedge clk);
    apb_wr(A_STAT, 32'h1);
    n_run++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL sim_w1c_irq: got %b want 1", irq);
    end
    exp_q.push_back(32'h1);
    apb_rd(A_STAT, rd);
    e = exp_q.pop_front(); n_run++;
    if (rd !== e) begin
      n_fail++; $display("FAIL sim_w1c_stat: got %h want %h", rd, e);
    end

    do_reset();
    apb_wr(A_LOAD, 32'd1);
    apb_wr(A_CTRL, 32'h0002_0007);
    repeat (4) @(negedge clk);
    apb_wr(A_LOAD, 32'd10);
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL sim_ld_irq: got %b want 0", irq);
    end
    exp_q.push_back(32'd10);
    apb_rd(A_CNT, rd);
    e = exp_q.pop_front(); n_run++;
    if (rd !== e) begin
      n_fail++; $display("FAIL sim_ld_cnt: got %h want %h", rd, e);
    end
    exp_q.push_back(32'h0);
    apb_rd(A_STAT, rd);
    e = exp_q.pop_front(); n_run++;
    if (rd !== e) begin
      n_fail++; $display("FAIL sim_ld_stat: got %h want %h", rd, e);
    end
    exp_q.push_back(32'd9);
    apb_rd(A_CNT, rd);
    e = exp_q.pop_front(); n_run++;
    if (rd !== e) begin
      n_fail++; $display("FAIL sim_ld_cnt9: got %h want %h", rd, e);
    end
  endtask

  task automatic test_readonly();
    logic [31:0] rd, e;
    logic [31:0] ra[5];
    logic [31:0] rv[5];
    do_reset();
    apb_wr(A_LOAD, 32'd7);
    apb_wr(A_CNT, 32'h55);
    apb_wr(A_CTRL, 32'hFFFF_FFF8);
    apb_wr(A_NONE, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    ra = '{A_CNT, A_CTRL, A_NONE, A_LOAD, A_STAT};
    rv = '{32'd7, 32'hFFFF_0000, 32'h0, 32'd7, 32'h0};
    foreach (ra[i]) begin
      exp_q.push_back(rv[i]);
      apb_rd(ra[i], rd);
      e = exp_q.pop_front(); n_run++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL ro_rd[%0d]: got %h want %h", i, rd, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e;
    logic [31:0] ra[4];
    do_reset();
    apb_wr(A_LOAD, 32'd0);
    apb_wr(A_CTRL, 32'h7);
    @(negedge clk);
    n_run++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL rm_irq_pre: got %b want 1", irq);
    end
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL rm_irq_async: got %b want 0", irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ra = '{A_CTRL, A_LOAD, A_CNT, A_STAT};
    foreach (ra[i]) begin
      exp_q.push_back(32'h0);
      apb_rd(ra[i], rd);
      e = exp_q.pop_front(); n_run++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL rm_rd[%h]: got %h want %h", ra[i], rd, e);
      end
    end
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL rm_irq_post: got %b want 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_simultaneous();
    test_readonly();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
